change_dispenser: RTL

Coin-return back end for the vending machine. It accepts a change amount in cents when a sale completes and drives the coin-ejector solenoids one coin at a time, using the fewest coins: greedy over 100, 50, 10 and 5 cents. It sits downstream of the vending FSM: `Deliver` feeds `Load` and `Money` feeds `Change`. Its per-coin outputs mirror the four coin inputs on the acceptance side.

---
 rtl/change_pkg.sv | 61 ++++++
 rtl/eject_timer.sv | 31 +++
 rtl/change_dispenser.sv | 129 ++++++++++++
 3 files changed

// File: rtl/change_pkg.sv
// Shared types and coin constants for the change dispenser.
// Greedy coin selection lives here so the FSM and any future users agree on it.
package change_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        PULSE,
        GAP,
        DONE
    } stateType;

    typedef enum logic [1:0] {
        DOLLAR,
        FIFTY,
        TEN,
        FIVE
    } coinType;

    localparam logic [7:0] DOLLAR_CENTS = 8'd100;
    localparam logic [7:0] FIFTY_CENTS  = 8'd50;
    localparam logic [7:0] TEN_CENTS    = 8'd10;
    localparam logic [7:0] FIVE_CENTS   = 8'd5;

    localparam int TIMER_W = 16;

    typedef struct packed {
        logic       valid;
        coinType    coin;
        logic [7:0] value;
    } pickType;

    // Largest coin not exceeding the remaining amount; valid=0 when under five cents.
    function automatic pickType pickCoin(input logic [7:0] remain);
        pickType p;
        logic [8:0] wide;
        wide    = {1'b0, remain};
        p.valid = 1'b1;
        p.coin  = DOLLAR;
        p.value = DOLLAR_CENTS;
        if (wide >= {1'b0, DOLLAR_CENTS}) begin
            p.coin  = DOLLAR;
            p.value = DOLLAR_CENTS;
        end else if (wide >= {1'b0, FIFTY_CENTS}) begin
            p.coin  = FIFTY;
            p.value = FIFTY_CENTS;
        end else if (wide >= {1'b0, TEN_CENTS}) begin
            p.coin  = TEN;
            p.value = TEN_CENTS;
        end else if (wide >= {1'b0, FIVE_CENTS}) begin
            p.coin  = FIVE;
            p.value = FIVE_CENTS;
        end else begin
            p.valid = 1'b0;
            p.coin  = FIVE;
            p.value = 8'd0;
        end
        return p;
    endfunction

endpackage

// File: rtl/eject_timer.sv
// Loadable down-counter timing the PULSE and GAP phases of the dispenser.
// lastCycle is high during the final cycle of a loaded interval.
module eject_timer
    import change_pkg::*;
(
    input  logic               CLK,
    input  logic               RST,
    input  logic               Enable,
    input  logic               timerLoad,
    input  logic [TIMER_W-1:0] loadValue,
    output logic               lastCycle
);

    logic [TIMER_W-1:0] count;

    always_ff @(posedge CLK) begin
        if (RST) begin
            count <= '0;
        end else if (Enable) begin
            if (timerLoad) begin
                count <= loadValue;
            end else if (count != '0) begin
                count <= count - 1'b1;
            end
        end
    end

    // A load of N gives N cycles, the last one flagged; zero is treated as expired.
    assign lastCycle = (count <= TIMER_W'(1));

endmodule

// File: rtl/change_dispenser.sv
// Coin-return back end: greedy 100/50/10/5 dispensing, one registered eject pulse at a time.
// Optional macro CHANGE_DISPENSER_COUNT_EN adds the CoinCount output.
module change_dispenser
    import change_pkg::*;
#(
    parameter int PULSE_CYCLES = 4,
    parameter int GAP_CYCLES   = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Enable,
    input  logic       Load,
    input  logic [7:0] Change,
    output logic       EjectDollar,
    output logic       EjectFifty,
    output logic       EjectTen,
    output logic       EjectFive,
    output logic       Busy,
    output logic       Done,
    output logic       Error
`ifdef CHANGE_DISPENSER_COUNT_EN
    ,
    output logic [7:0] CoinCount
`endif
);

    stateType           state;
    logic [7:0]         remain;
    pickType            pick;
    logic               timerLoad;
    logic [TIMER_W-1:0] timerValue;
    logic               timerLast;

    assign pick = pickCoin(remain);

    always_comb begin
        timerLoad  = 1'b0;
        timerValue = TIMER_W'(PULSE_CYCLES);
        if (state == SELECT && pick.valid) begin
            timerLoad  = 1'b1;
            timerValue = TIMER_W'(PULSE_CYCLES);
        end else if (state == PULSE && timerLast) begin
            timerLoad  = 1'b1;
            timerValue = TIMER_W'(GAP_CYCLES);
        end
    end

    eject_timer u_eject_timer (
        .CLK       (CLK),
        .RST       (RST),
        .Enable    (Enable),
        .timerLoad (timerLoad),
        .loadValue (timerValue),
        .lastCycle (timerLast)
    );

    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values; blocking writes would chain through the case.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            remain      <= 8'd0;
            EjectDollar <= 1'b0;
            EjectFifty  <= 1'b0;
            EjectTen    <= 1'b0;
            EjectFive   <= 1'b0;
            Busy        <= 1'b0;
            Done        <= 1'b0;
            Error       <= 1'b0;
`ifdef CHANGE_DISPENSER_COUNT_EN
            CoinCount   <= 8'd0;
`endif
        end else if (Enable) begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Load) begin
                        remain <= Change;
                        Error  <= 1'b0;
                        Busy   <= 1'b1;
                        state  <= SELECT;
`ifdef CHANGE_DISPENSER_COUNT_EN
                        CoinCount <= 8'd0;
`endif
                    end
                end
                SELECT: begin
                    if (pick.valid) begin
                        remain      <= remain - pick.value;
                        EjectDollar <= (pick.coin == DOLLAR);
                        EjectFifty  <= (pick.coin == FIFTY);
                        EjectTen    <= (pick.coin == TEN);
                        EjectFive   <= (pick.coin == FIVE);
                        state       <= PULSE;
`ifdef CHANGE_DISPENSER_COUNT_EN
                        if (CoinCount != 8'hFF) CoinCount <= CoinCount + 8'd1;
`endif
                    end else begin
                        // Sub-nickel residue cannot be paid out; flag and drop it.
                        if (remain != 8'd0) Error <= 1'b1;
                        remain <= 8'd0;
                        Done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                PULSE: begin
                    if (timerLast) begin
                        EjectDollar <= 1'b0;
                        EjectFifty  <= 1'b0;
                        EjectTen    <= 1'b0;
                        EjectFive   <= 1'b0;
                        state       <= GAP;
                    end
                end
                GAP: begin
                    if (timerLast) state <= SELECT;
                end
                DONE: begin
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
